data_cache: RTL and testbench

DATA_CACHE -- requirements
Module: data_cache

---
 rtl/data_cache_if.sv | 49 ++++
 rtl/data_cache.sv | 165 ++++++++++++++++
 tb/tb_data_cache.sv | 339 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/data_cache_if.sv
//------------------------------------------------------------------------------
// data_cache_if : CPU-side and memory-side bus bundle for data_cache.
// Revision 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface data_cache_if;
  // CPU side
  logic        cpu_req_i;
  logic        cpu_wr_i;
  logic [31:0] cpu_addr_i;
  logic [31:0] cpu_wdata_i;
  logic [1:0]  cpu_size_i;
  logic        cpu_ready_o;
  logic        cpu_rvalid_o;
  logic [31:0] cpu_rdata_o;
  // Memory side
  logic        mem_rd_req_o;
  logic [31:0] mem_rd_addr_o;
  logic [31:0] mem_rdata_i;
  logic        mem_rvalid_i;
  logic        mem_wr_req_o;
  logic [31:0] mem_wr_addr_o;
  logic [31:0] mem_wdata_o;
  logic [3:0]  mem_wstrb_o;
  logic        mem_wr_ack_i;

  // Cache view
  modport slave (
    input  cpu_req_i, cpu_wr_i, cpu_addr_i, cpu_wdata_i, cpu_size_i,
    output cpu_ready_o, cpu_rvalid_o, cpu_rdata_o,
    output mem_rd_req_o, mem_rd_addr_o,
    input  mem_rdata_i, mem_rvalid_i,
    output mem_wr_req_o, mem_wr_addr_o, mem_wdata_o, mem_wstrb_o,
    input  mem_wr_ack_i
  );

  // CPU + memory environment view
  modport master (
    output cpu_req_i, cpu_wr_i, cpu_addr_i, cpu_wdata_i, cpu_size_i,
    input  cpu_ready_o, cpu_rvalid_o, cpu_rdata_o,
    input  mem_rd_req_o, mem_rd_addr_o,
    output mem_rdata_i, mem_rvalid_i,
    input  mem_wr_req_o, mem_wr_addr_o, mem_wdata_o, mem_wstrb_o,
    output mem_wr_ack_i
  );
endinterface

`default_nettype wire

// File: rtl/data_cache.sv
//------------------------------------------------------------------------------
// data_cache : direct-mapped, write-through / no-write-allocate data cache.
// Revision 1.0
//------------------------------------------------------------------------------
`default_nettype none

module data_cache #(
  parameter int SETS       = 64,
  parameter int LINE_WORDS = 4
) (
  input  logic        clk,
  input  logic        rst,
  data_cache_if.slave bus
);

  localparam int OW = $clog2(LINE_WORDS);
  localparam int IW = $clog2(SETS);
  localparam int TW = 32 - IW - OW - 2;
  localparam logic [OW-1:0] LAST_WORD = OW'(LINE_WORDS - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REFILL = 2'd1,
    RESP   = 2'd2,
    WRITE  = 2'd3
  } state_t;

  state_t         state_q;
  logic [31:0]    data_q  [SETS*LINE_WORDS];
  logic [TW-1:0]  tag_q   [SETS];
  logic [SETS-1:0] valid_q;
  logic [OW-1:0]  cnt_q;
  logic [31:2]    addr_q;
  logic           rvalid_q;
  logic [31:0]    rdata_q;
  logic           rd_req_q;
  logic           wr_req_q;
  logic [31:2]    wr_addr_q;
  logic [31:0]    wdata_q;
  logic [3:0]     wstrb_q;

  logic [TW-1:0]  req_tag, lat_tag;
  logic [IW-1:0]  req_idx, lat_idx;
  logic [OW-1:0]  req_word, lat_word;
  logic           hit, accept, beat, last_beat;
  logic [3:0]     strb_d;
  logic [31:0]    wdata_d;

  assign req_tag  = bus.cpu_addr_i[31 -: TW];
  assign req_idx  = bus.cpu_addr_i[OW+2 +: IW];
  assign req_word = bus.cpu_addr_i[2 +: OW];
  assign lat_tag  = addr_q[31 -: TW];
  assign lat_idx  = addr_q[OW+2 +: IW];
  assign lat_word = addr_q[2 +: OW];

  assign hit       = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
  assign accept    = bus.cpu_req_i && (state_q == IDLE);
  assign beat      = (state_q == REFILL) && bus.mem_rvalid_i;
  assign last_beat = beat && (cnt_q == LAST_WORD);

  // Byte lanes follow the size; address bits below the access size are ignored.
  always_comb begin
    strb_d  = 4'b1111;
    wdata_d = bus.cpu_wdata_i;
    case (bus.cpu_size_i)
      2'b01: begin
        strb_d  = bus.cpu_addr_i[1] ? 4'b1100 : 4'b0011;
        wdata_d = {2{bus.cpu_wdata_i[15:0]}};
      end
      2'b10: begin
        strb_d  = 4'b0001 << bus.cpu_addr_i[1:0];
        wdata_d = {4{bus.cpu_wdata_i[7:0]}};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      valid_q   <= '0;
      cnt_q     <= '0;
      addr_q    <= '0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rd_req_q  <= 1'b0;
      wr_req_q  <= 1'b0;
      wr_addr_q <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
    end else begin
      rvalid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            if (bus.cpu_wr_i) begin
              wr_addr_q <= bus.cpu_addr_i[31:2];
              wdata_q   <= wdata_d;
              wstrb_q   <= strb_d;
              wr_req_q  <= 1'b1;
              state_q   <= WRITE;
            end else if (hit) begin
              rvalid_q <= 1'b1;
              rdata_q  <= data_q[{req_idx, req_word}];
            end else begin
              addr_q   <= bus.cpu_addr_i[31:2];
              cnt_q    <= '0;
              rd_req_q <= 1'b1;
              state_q  <= REFILL;
            end
          end
        end
        REFILL: begin
          if (beat) begin
            cnt_q <= cnt_q + 1'b1;
            // Capture the requested word as it streams past.
            if (cnt_q == lat_word) rdata_q <= bus.mem_rdata_i;
            if (last_beat) begin
              valid_q[lat_idx] <= 1'b1;
              rd_req_q         <= 1'b0;
              rvalid_q         <= 1'b1;
              state_q          <= RESP;
            end
          end
        end
        RESP: state_q <= IDLE;
        WRITE: begin
          if (bus.mem_wr_ack_i) begin
            wr_req_q <= 1'b0;
            state_q  <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Data and tag storage carry no reset; validity is tracked separately.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (beat) begin
        data_q[{lat_idx, cnt_q}] <= bus.mem_rdata_i;
        if (last_beat) tag_q[lat_idx] <= lat_tag;
      end
      if (accept && bus.cpu_wr_i && hit) begin
        for (int b = 0; b < 4; b++) begin
          if (strb_d[b]) data_q[{req_idx, req_word}][8*b +: 8] <= wdata_d[8*b +: 8];
        end
      end
    end
  end

  assign bus.cpu_ready_o   = (state_q == IDLE);
  assign bus.cpu_rvalid_o  = rvalid_q;
  assign bus.cpu_rdata_o   = rdata_q;
  assign bus.mem_rd_req_o  = rd_req_q;
  assign bus.mem_rd_addr_o = {addr_q[31:OW+2], {(OW+2){1'b0}}};
  assign bus.mem_wr_req_o  = wr_req_q;
  assign bus.mem_wr_addr_o = {wr_addr_q, 2'b00};
  assign bus.mem_wdata_o   = wdata_q;
  assign bus.mem_wstrb_o   = wstrb_q;

endmodule

`default_nettype wire

// File: tb/tb_data_cache.sv
//------------------------------------------------------------------------------
// tb_data_cache : self-checking bench for data_cache (SETS=4, LINE_WORDS=4).
// Revision 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_data_cache;

  logic clk;
  logic rst;
  data_cache_if bus();

  data_cache #(.SETS(4), .LINE_WORDS(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_vec = 0;
  int n_err = 0;

  // Backing memory: sparse, with a deterministic default pattern.
  logic [31:0] mem [logic [29:0]];
  int  gap_max     = 0;
  int  ack_dly_cfg = 0;
  bit  inject_junk = 0;

  // Reference hit model: which tag each set holds.
  bit          mv [4];
  logic [25:0] mt [4];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] memval(input logic [31:0] a);
    if (mem.exists(a[31:2])) return mem[a[31:2]];
    return {a[31:2], 2'b00} ^ 32'h3C5A_96E1;
  endfunction

  function automatic logic [3:0] ref_strb(input logic [31:0] a, input logic [1:0] sz);
    if (sz == 2'b01) return a[1] ? 4'b1100 : 4'b0011;
    if (sz == 2'b10) return 4'(1 << a[1:0]);
    return 4'b1111;
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [31:0] wd, input logic [1:0] sz);
    if (sz == 2'b01) return {2{wd[15:0]}};
    if (sz == 2'b10) return {4{wd[7:0]}};
    return wd;
  endfunction

  // Memory responder: refill beats with optional gaps, delayed write acks.
  initial begin : responder
    int          beat, gap, wcnt;
    bit          in_wr;
    logic [31:0] s_addr, s_data, cur;
    logic [3:0]  s_strb;
    beat = 0; gap = 0; wcnt = 0; in_wr = 0;
    bus.mem_rvalid_i = 1'b0;
    bus.mem_rdata_i  = '0;
    bus.mem_wr_ack_i = 1'b0;
    forever begin
      @(negedge clk);
      bus.mem_rvalid_i = 1'b0;
      bus.mem_wr_ack_i = 1'b0;
      if (rst) begin
        beat = 0; gap = 0; in_wr = 0;
      end else begin
        if (bus.mem_rd_req_o) begin
          if (gap > 0) gap--;
          else begin
            bus.mem_rvalid_i = 1'b1;
            bus.mem_rdata_i  = memval(bus.mem_rd_addr_o + 32'(4 * beat));
            beat++;
            gap = $urandom_range(0, gap_max);
          end
        end else begin
          beat = 0; gap = 0;
          if (inject_junk) begin
            bus.mem_rvalid_i = 1'b1;
            bus.mem_rdata_i  = 32'hDEAD_BEEF;
          end
        end
        if (bus.mem_wr_req_o) begin
          if (!in_wr) begin
            in_wr  = 1;
            s_addr = bus.mem_wr_addr_o;
            s_data = bus.mem_wdata_o;
            s_strb = bus.mem_wstrb_o;
            wcnt   = ack_dly_cfg;
          end else begin
            chk("wr_stable_addr", bus.mem_wr_addr_o, s_addr);
            chk("wr_stable_data", bus.mem_wdata_o, s_data);
            chk("wr_stable_strb", bus.mem_wstrb_o, s_strb);
          end
          if (wcnt == 0) begin
            bus.mem_wr_ack_i = 1'b1;
            cur = memval(s_addr);
            for (int b = 0; b < 4; b++)
              if (s_strb[b]) cur[8*b +: 8] = s_data[8*b +: 8];
            mem[s_addr[31:2]] = cur;
          end else wcnt--;
        end else begin
          in_wr = 0;
          if (inject_junk) bus.mem_wr_ack_i = 1'b1;
        end
      end
    end
  end

  initial begin : monitor
    forever begin
      @(negedge clk);
      if (bus.mem_rd_req_o && bus.mem_wr_req_o) begin
        n_err++;
        $display("FAIL rd_wr_overlap: got rd=1 wr=1 expected not both");
      end
    end
  end

  initial begin : watchdog
    #600000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int s = 0; s < 4; s++) mv[s] = 0;
  endtask

  task automatic do_load(input logic [31:0] a, input logic [1:0] sz,
                         output logic [31:0] d, output bit miss,
                         output int cyc, output logic [31:0] rda);
    @(negedge clk);
    chk("ld_ready", bus.cpu_ready_o, 1);
    bus.cpu_req_i = 1'b1; bus.cpu_wr_i = 1'b0;
    bus.cpu_addr_i = a; bus.cpu_size_i = sz; bus.cpu_wdata_i = $urandom;
    @(negedge clk);
    bus.cpu_req_i = 1'b0;
    miss = 0; cyc = 1; rda = '0;
    while (!bus.cpu_rvalid_o && cyc < 200) begin
      if (bus.mem_rd_req_o && !miss) begin
        miss = 1;
        rda  = bus.mem_rd_addr_o;
      end
      @(negedge clk);
      cyc++;
    end
    if (!bus.cpu_rvalid_o) chk("ld_timeout", 0, 1);
    d = bus.cpu_rdata_o;
  endtask

  task automatic do_store(input logic [31:0] a, input logic [31:0] wd,
                          input logic [1:0] sz, input int dly,
                          output logic [3:0] st, output logic [31:0] wdo,
                          output logic [31:0] wa);
    int n;
    @(negedge clk);
    ack_dly_cfg = dly;
    bus.cpu_req_i = 1'b1; bus.cpu_wr_i = 1'b1;
    bus.cpu_addr_i = a; bus.cpu_wdata_i = wd; bus.cpu_size_i = sz;
    @(negedge clk);
    bus.cpu_req_i = 1'b0; bus.cpu_wr_i = 1'b0;
    chk("st_wr_req", bus.mem_wr_req_o, 1);
    st = bus.mem_wstrb_o; wdo = bus.mem_wdata_o; wa = bus.mem_wr_addr_o;
    n = 0;
    while (!bus.cpu_ready_o && n < 200) begin
      chk("st_no_rvalid", bus.cpu_rvalid_o, 0);
      @(negedge clk);
      n++;
    end
    if (!bus.cpu_ready_o) chk("st_timeout", 0, 1);
  endtask

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [1:0]  sz;
    int          dly;
    bit          miss;
    logic [31:0] rdata;
    logic [3:0]  strb;
    logic [31:0] wdo;
  } vec_t;

  vec_t tv [13];

  initial begin : main
    logic [31:0] d, rda, wdo, wa, a, wd, e;
    logic [3:0]  st;
    logic [1:0]  sz;
    bit          miss, hit;
    int          cyc, idx;

    tv[0]  = '{0, 32'h100, 0, 2'b00, 0, 1, 32'h0000_00A0, 0, 0};
    tv[1]  = '{0, 32'h108, 0, 2'b00, 0, 0, 32'h0000_00A2, 0, 0};
    tv[2]  = '{1, 32'h103, 32'h55, 2'b10, 3, 0, 0, 4'b1000, 32'h5555_5555};
    tv[3]  = '{0, 32'h100, 0, 2'b00, 0, 0, 32'h5500_00A0, 0, 0};
    tv[4]  = '{1, 32'h202, 32'hBEEF, 2'b01, 0, 0, 0, 4'b1100, 32'hBEEF_BEEF};
    tv[5]  = '{0, 32'h202, 0, 2'b01, 0, 1, 32'hBEEF_3344, 0, 0};
    tv[6]  = '{0, 32'h140, 0, 2'b00, 0, 1, 32'h0000_00B0, 0, 0};
    tv[7]  = '{0, 32'h100, 0, 2'b00, 0, 1, 32'h5500_00A0, 0, 0};
    tv[8]  = '{1, 32'h10B, 32'hCAFE_F00D, 2'b00, 1, 0, 0, 4'b1111, 32'hCAFE_F00D};
    tv[9]  = '{0, 32'h108, 0, 2'b00, 0, 0, 32'hCAFE_F00D, 0, 0};
    tv[10] = '{0, 32'h10C, 0, 2'b10, 0, 0, 32'h0000_00A3, 0, 0};
    tv[11] = '{1, 32'h141, 32'h7E, 2'b10, 0, 0, 0, 4'b0010, 32'h7E7E_7E7E};
    tv[12] = '{0, 32'h140, 0, 2'b00, 0, 1, 32'h0000_7EB0, 0, 0};

    for (int i = 0; i < 4; i++) begin
      mem[30'((32'h100 >> 2) + i)] = 32'hA0 + 32'(i);
      mem[30'((32'h140 >> 2) + i)] = 32'hB0 + 32'(i);
    end
    mem[30'(32'h200 >> 2)] = 32'h1122_3344;

    rst = 1'b1;
    bus.cpu_req_i = 1'b0; bus.cpu_wr_i = 1'b0; bus.cpu_addr_i = '0;
    bus.cpu_wdata_i = '0; bus.cpu_size_i = '0;
    for (int s = 0; s < 4; s++) mv[s] = 0;
    repeat (2) @(negedge clk);
    chk("rst_ready",  bus.cpu_ready_o,  1);
    chk("rst_rvalid", bus.cpu_rvalid_o, 0);
    chk("rst_rd_req", bus.mem_rd_req_o, 0);
    chk("rst_wr_req", bus.mem_wr_req_o, 0);
    rst = 1'b0;

    // Directed table
    gap_max = 0;
    for (int i = 0; i < 13; i++) begin
      if (tv[i].wr) begin
        do_store(tv[i].addr, tv[i].wd, tv[i].sz, tv[i].dly, st, wdo, wa);
        chk($sformatf("tv%0d_strb", i), st, tv[i].strb);
        chk($sformatf("tv%0d_wdata", i), wdo, tv[i].wdo);
        chk($sformatf("tv%0d_waddr", i), wa, tv[i].addr & ~32'h3);
      end else begin
        do_load(tv[i].addr, tv[i].sz, d, miss, cyc, rda);
        chk($sformatf("tv%0d_rdata", i), d, tv[i].rdata);
        chk($sformatf("tv%0d_miss", i), miss, tv[i].miss);
        if (tv[i].miss) begin
          chk($sformatf("tv%0d_rdaddr", i), rda, tv[i].addr & ~32'hF);
          chk($sformatf("tv%0d_miss_lat", i), cyc, 5);
        end else chk($sformatf("tv%0d_hit_lat", i), cyc, 1);
      end
    end

    // Back-to-back load hits
    do_reset();
    do_load(32'h100, 2'b00, d, miss, cyc, rda);
    chk("b2b_fill", d, memval(32'h100));
    @(negedge clk);
    bus.cpu_req_i = 1'b1; bus.cpu_wr_i = 1'b0; bus.cpu_addr_i = 32'h104;
    @(negedge clk);
    chk("b2b_rv0", bus.cpu_rvalid_o, 1);
    chk("b2b_d0", bus.cpu_rdata_o, 32'hA1);
    bus.cpu_addr_i = 32'h10C;
    @(negedge clk);
    bus.cpu_req_i = 1'b0;
    chk("b2b_rv1", bus.cpu_rvalid_o, 1);
    chk("b2b_d1", bus.cpu_rdata_o, 32'hA3);
    chk("b2b_no_rd", bus.mem_rd_req_o, 0);

    // Reset after the second refill beat
    do_reset();
    @(negedge clk);
    bus.cpu_req_i = 1'b1; bus.cpu_wr_i = 1'b0; bus.cpu_addr_i = 32'h140;
    @(negedge clk);
    bus.cpu_req_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_ready", bus.cpu_ready_o, 1);
    chk("mid_rst_rd_req", bus.mem_rd_req_o, 0);
    @(negedge clk);
    rst = 1'b0;
    for (int s = 0; s < 4; s++) mv[s] = 0;
    do_load(32'h140, 2'b00, d, miss, cyc, rda);
    chk("mid_rst_miss", miss, 1);
    chk("mid_rst_lat", cyc, 5);
    chk("mid_rst_data", d, memval(32'h140));

    // Stray memory strobes while idle must be ignored
    @(negedge clk);
    inject_junk = 1;
    repeat (2) @(negedge clk);
    inject_junk = 0;
    chk("junk_ready", bus.cpu_ready_o, 1);
    do_load(32'h140, 2'b00, d, miss, cyc, rda);
    chk("junk_hit", miss, 0);
    chk("junk_data", d, memval(32'h140));

    // Randomized traffic against the reference model
    do_reset();
    for (int i = 0; i < 300; i++) begin
      a  = 32'h1000 + ($urandom_range(0, 2) << 6) + $urandom_range(0, 63);
      sz = 2'($urandom_range(0, 3));
      gap_max = $urandom_range(0, 2);
      if ($urandom_range(0, 9) < 3) begin
        wd = $urandom;
        do_store(a, wd, sz, $urandom_range(0, 3), st, wdo, wa);
        chk("rnd_strb", st, ref_strb(a, sz));
        chk("rnd_wdata", wdo, ref_wdata(wd, sz));
        chk("rnd_waddr", wa, a & ~32'h3);
      end else begin
        e   = memval(a);
        idx = int'(a[5:4]);
        hit = mv[idx] && (mt[idx] == a[31:6]);
        do_load(a, sz, d, miss, cyc, rda);
        chk("rnd_rdata", d, e);
        chk("rnd_miss", miss, !hit);
        if (hit) chk("rnd_hit_lat", cyc, 1);
        else chk("rnd_rdaddr", rda, a & ~32'hF);
        mv[idx] = 1;
        mt[idx] = a[31:6];
      end
    end

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
